fir_pipelined_param: RTL
========================

// Module: fir_pipelined_param
// PURPOSE
// - Parametrised, pipelined direct-form FIR filter: TAPS signed taps, DATA_W-bit samples, COEF_W-bit coefficients.
// - Coefficients are runtime-loadable; a valid qualifier travels with each sample.
// - Successor to the 5-tap 1-bit cutset filter: registered products plus a registered adder tree give a
//   fixed pipeline latency and one sample per clock.
// - Sits between the sample source and the downstream decimator/DSP stage.
// PARAMETERS
// - DATA_W   8    input sample width, signed two's complement
// - COEF_W   8    coefficient width, signed
// - TAPS     5    number of taps, >=2
// - OUT_W    16   output width, <= ACC_W
// - ACC_W (localparam) = DATA_W+COEF_W+$clog2(TAPS), full-precision accumulator width
// - LAT (localparam)   = 2+$clog2(TAPS), in_valid -> out_valid latency in clocks
// PORTS
// - clk        in   1        rising-edge clock
// - rst        in   1        asynchronous reset, active-low
// - clr        in   1        synchronous clear of delay line and valid pipe
// - in_valid   in   1        X is a new sample this cycle
// - X          in   DATA_W   input sample
// - coef_load  in   1        shift coef_in into coefficient chain
// - coef_in    in   COEF_W   coefficient word
// - coef_done  out  1        TAPS coefficients loaded since reset
// - out_valid  out  1        Y valid this cycle
// - Y          out  OUT_W    filter output
// BEHAVIOUR
// - Reset (rst=0, async): delay line, coefficient regs, pipeline regs = 0; Y=0, out_valid=0, coef_done=0,
//   load counter=0.
// - Delay line x[0..TAPS-1]: shifts only when in_valid=1 (x[0]<=X); holds otherwise.
// - Stage 1: p[k] <= x[k]*h[k], full DATA_W+COEF_W signed product, registered every cycle.
// - Tree: pairwise sign-extended adds; each level registered; an odd leftover passes through a register.
// - Output register: Y <= acc truncated to OUT_W LSBs (wrap) unless FIR_SAT_EN is defined.
// - Valid pipe: LAT-deep shift register of in_valid; out_valid is its last stage.
// - No backpressure: the pipeline advances every cycle; input gaps appear as out_valid gaps.
// - Y holds its last value while out_valid=0.
// - Output for sample n = sum h[k]*x[n-k] over the last TAPS valid samples.
// - Coefficient load: on coef_load, h[TAPS-1] <= coef_in and h[k] <= h[k+1].
//   - After TAPS loads, h[0] holds the first word loaded.
//   - 4-bit+ saturating counter; coef_done=1 once count reaches TAPS; stays 1 until reset.
// - Simultaneous coef_load and in_valid: the product uses pre-load coefficients; the new coefficients apply
//   from the next cycle.
// - clr=1: delay line and valid pipe zeroed next edge. Coefficients, coef_done and Y are kept. clr wins over
//   in_valid in the same cycle.
// - Reset mid-operation: in-flight samples are discarded; coefficients must be reloaded.
// CONFIGURATION
// - FIR_SAT_EN defined: if acc exceeds the OUT_W signed range, Y clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
// - FIR_SAT_EN undefined: Y = acc[OUT_W-1:0] (two's-complement wrap). Latency is identical in both builds.
// STRUCTURE
// - Package fir_pkg: clog2 helper, default widths, sat_clamp function.
// - Sub-module fir_adder_tree: ACC_W-wide registered tree, parametrised by leaf count.
// - Top holds the delay line, coefficient chain, multipliers and valid pipe.
// TESTING
// - Load h=1,2,3,4,5 (TAPS=5); impulse X=1 then zeros, all valid
//   -> Y=1,2,3,4,5,0 starting LAT=5 clocks after the impulse.
// - Step X=10 continuous -> Y settles at 150 after TAPS samples; out_valid stays 1.
// - in_valid toggling 1,0,1,0 with the impulse -> outputs match the dense case, spaced on valid cycles only.
// - h all=127, X=127 continuous, OUT_W=16 -> FIR_SAT_EN: Y=32767; without: Y=80645 mod 2^16 = 15109.
// - coef_load concurrent with a sample -> that sample uses the old h. coef_done rises on the 5th load.
// - rst low mid-stream -> Y=0, out_valid=0 immediately. clr mid-stream -> out_valid drops, coefficients kept.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the pipelined FIR filter.
//   clog2       - ceil(log2(n)) for constant width and latency arithmetic
//   node_count  - number of adder-tree nodes left after a given number of pairwise levels
//   sat_clamp   - clamps a signed value into a signed out_w-bit range
//   DEF_*       - default datapath widths and tap count
package fir_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_TAPS   = 5;
  localparam int DEF_OUT_W  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Each tree level halves the node count, rounding up for an odd leftover.
  function automatic int node_count(input int leaves, input int level);
    int n;
    n = leaves;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/fir_pipelined_param_if.sv
// Sample / coefficient / result bundle of the pipelined FIR filter.
//   in_valid, X         - sample strobe and signed sample
//   coef_load, coef_in  - coefficient shift strobe and signed coefficient word
//   coef_done           - all taps loaded since reset
//   out_valid, Y        - result strobe and signed result
// Modport master is the sample source side, slave is the filter side.
interface fir_pipelined_param_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] X;
  logic                     coef_load;
  logic signed [COEF_W-1:0] coef_in;
  logic                     coef_done;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  Y;

  modport master (
    output in_valid, X, coef_load, coef_in,
    input  coef_done, out_valid, Y
  );

  modport slave (
    input  in_valid, X, coef_load, coef_in,
    output coef_done, out_valid, Y
  );
endinterface

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree.
//   clk, rst (async active-low)
//   leaves [LEAVES] - W-bit signed inputs, already sign-extended to the full accumulator width
//   root            - registered sum, clog2(LEAVES) clocks after the leaves
// Every level is a register stage; an odd leftover node is carried through a register so all
// paths through the tree have equal latency.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int LEAVES = 5,
  parameter int W      = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] leaves [LEAVES],
  output logic signed [W-1:0] root
);

  localparam int LEVELS = clog2(LEAVES);

  for (genvar i = 0; i <= LEVELS; i++) begin : g_lvl
    localparam int N = node_count(LEAVES, i);
    logic signed [W-1:0] node [N];

    if (i == 0) begin : g_leaf
      assign node = leaves;
    end else begin : g_add
      localparam int NP = node_count(LEAVES, i - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        logic signed [W-1:0] q;
        if (2 * j + 1 < NP) begin : g_pair
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) q <= '0;
            else      q <= g_lvl[i-1].node[2*j] + g_lvl[i-1].node[2*j+1];
          end
        end else begin : g_pass
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) q <= '0;
            else      q <= g_lvl[i-1].node[2*j];
          end
        end
        assign node[j] = q;
      end
    end
  end

  assign root = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/fir_pipelined_param.sv
// Pipelined direct-form FIR filter with runtime-loadable coefficients.
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-low
//   clr  - synchronous clear of delay line and valid pipe (coefficients and Y kept)
//   bus  - slave side of fir_pipelined_param_if (samples in, coefficients in, results out)
// Latency in_valid -> out_valid is 2 + clog2(TAPS) clocks, one sample per clock, no backpressure.
// Build option: define FIR_SAT_EN to clamp Y to the signed OUT_W range; otherwise Y is the
// two's-complement wrap of the accumulator. Latency is the same in both builds.
module fir_pipelined_param
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  fir_pipelined_param_if.slave bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int LEVELS = clog2(TAPS);
  localparam int ACC_W  = PROD_W + LEVELS;
  localparam int LAT    = 2 + LEVELS;
  localparam int CNT_W  = (clog2(TAPS + 1) > 4) ? clog2(TAPS + 1) : 4;

  logic signed [DATA_W-1:0] x_p0   [TAPS];
  logic signed [DATA_W-1:0] x_next [TAPS];
  logic signed [COEF_W-1:0] h      [TAPS];
  logic signed [PROD_W-1:0] prod_p1 [TAPS];
  logic signed [ACC_W-1:0]  leaf   [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y_next;
  logic signed [OUT_W-1:0]  y_p;
  logic [LAT-1:0]           vld_p;
  logic [CNT_W-1:0]         load_cnt;

  // Next delay-line contents. Products are formed from this view so the sample entering the
  // line is multiplied at the same edge it is captured, keeping latency at 2 + tree depth.
  always_comb begin
    x_next = x_p0;
    if (clr) begin
      for (int k = 0; k < TAPS; k++) x_next[k] = '0;
    end else if (bus.in_valid) begin
      x_next[0] = bus.X;
      for (int k = 1; k < TAPS; k++) x_next[k] = x_p0[k-1];
    end
  end

  // Stage p0: delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) x_p0[k] <= '0;
    end else begin
      x_p0 <= x_next;
    end
  end

  // Coefficient chain: new words enter at the top, so the first word ends up in h[0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) h[k] <= '0;
      load_cnt <= '0;
    end else if (bus.coef_load) begin
      for (int k = 0; k < TAPS - 1; k++) h[k] <= h[k+1];
      h[TAPS-1] <= bus.coef_in;
      if (load_cnt != CNT_W'(TAPS)) load_cnt <= load_cnt + CNT_W'(1);
    end
  end

  assign bus.coef_done = (load_cnt == CNT_W'(TAPS));

  // Stage p1: products. h is read before a concurrent load takes effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= PROD_W'(x_next[k]) * PROD_W'(h[k]);
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_leaf
    assign leaf[k] = ACC_W'(prod_p1[k]);
  end

  // Tree stages: clog2(TAPS) registered levels
  fir_adder_tree #(
    .LEAVES (TAPS),
    .W      (ACC_W)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .leaves (leaf),
    .root   (acc)
  );

`ifdef FIR_SAT_EN
  assign y_next = OUT_W'(sat_clamp(64'(acc), OUT_W));
`else
  assign y_next = OUT_W'(acc);
`endif

  // Output stage: Y only moves for a valid result and is frozen by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_p <= '0;
    end else if (vld_p[LAT-2] && !clr) begin
      y_p <= y_next;
    end
  end

  // Valid pipe runs alongside the data, LAT deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p <= '0;
    else if (clr) vld_p <= '0;
    else vld_p <= {vld_p[LAT-2:0], bus.in_valid};
  end

  assign bus.out_valid = vld_p[LAT-1];
  assign bus.Y         = y_p;

endmodule
